speck_key_schedule: RTL and testbench



---
 rtl/speck_key_schedule.sv | 114 +++++++++++
 tb/tb_speck_key_schedule.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/speck_key_schedule.sv
// Iterative SPECK64/128 key expansion: one master key in, ROUNDS round keys out on a valid/ready stream.
// Optional round-key register file for reverse-order readback is enabled by defining SPECK_RK_STORE_EN.
module speck_key_schedule #(
  parameter int WORD      = 32,
  parameter int ROUNDS    = 27,
  parameter int KEY_WORDS = 4,
  parameter int ALPHA     = 8,
  parameter int BETA      = 3,
  parameter int IDX_W     = $clog2(ROUNDS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      key_valid,
  output logic                      key_ready,
  input  logic [WORD*KEY_WORDS-1:0] key,
  output logic                      rk_valid,
  input  logic                      rk_ready,
  output logic [WORD-1:0]           rk_data,
  output logic [IDX_W-1:0]          rk_index,
  output logic                      rk_last
`ifdef SPECK_RK_STORE_EN
  ,
  input  logic [IDX_W-1:0]          rk_raddr,
  output logic [WORD-1:0]           rk_rdata
`endif
);

  localparam int ROT_A = ALPHA % WORD;
  localparam int ROT_B = BETA % WORD;
  localparam int L_WORDS = KEY_WORDS - 1;
  localparam logic [IDX_W-1:0] PENULT_IDX = IDX_W'(ROUNDS - 2);

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state;
  logic [WORD-1:0] l_buf [L_WORDS];
  logic [WORD-1:0] l_ror;
  logic [WORD-1:0] k_rol;
  logic [WORD-1:0] l_new;
  logic [WORD-1:0] k_next;
  logic            rk_fire;

  assign rk_fire = rk_valid && rk_ready;

  // rk_data doubles as the running k register, so only the l words need a separate buffer.
  always_comb begin
    l_ror  = (l_buf[0] >> ROT_A) | (l_buf[0] << (WORD - ROT_A));
    k_rol  = (rk_data << ROT_B) | (rk_data >> (WORD - ROT_B));
    l_new  = (rk_data + l_ror) ^ WORD'(rk_index);
    k_next = k_rol ^ l_new;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      key_ready <= 1'b1;
      rk_valid  <= 1'b0;
      rk_data   <= '0;
      rk_index  <= '0;
      rk_last   <= 1'b0;
      for (int j = 0; j < L_WORDS; j++) l_buf[j] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (key_valid) begin
            rk_data <= key[WORD-1:0];
            for (int j = 0; j < L_WORDS; j++) l_buf[j] <= key[WORD*(j+1) +: WORD];
            rk_index  <= '0;
            rk_valid  <= 1'b1;
            rk_last   <= (ROUNDS == 1);
            key_ready <= 1'b0;
            state     <= RUN;
          end
        end
        RUN: begin
          if (rk_fire) begin
            if (rk_last) begin
              rk_valid  <= 1'b0;
              rk_last   <= 1'b0;
              key_ready <= 1'b1;
              state     <= IDLE;
            end else begin
              for (int j = 0; j < L_WORDS - 1; j++) l_buf[j] <= l_buf[j+1];
              l_buf[L_WORDS-1] <= l_new;
              rk_data  <= k_next;
              rk_index <= rk_index + 1'b1;
              rk_last  <= (rk_index == PENULT_IDX);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SPECK_RK_STORE_EN
  logic [WORD-1:0] rk_store [ROUNDS];

  // Each key is captured as it is handed off, so a later job overwrites entries in emission order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < ROUNDS; j++) rk_store[j] <= '0;
    end else if (rk_fire) begin
      rk_store[rk_index] <= rk_data;
    end
  end

  always_comb begin
    rk_rdata = '0;
    if (int'(rk_raddr) < ROUNDS) rk_rdata = rk_store[rk_raddr];
  end
`endif

endmodule

// File: tb/tb_speck_key_schedule.sv
// Randomized self-checking bench for speck_key_schedule against a plain-arithmetic SPECK64/128 schedule model.
// Covers reset, the reference vector, backpressure, busy-key rejection, mid-job reset and optional readback.
module tb_speck_key_schedule;

  localparam int ROUNDS = 27;
  localparam int KW     = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         key_valid;
  logic         key_ready;
  logic [127:0] key;
  logic         rk_valid;
  logic         rk_ready;
  logic [31:0]  rk_data;
  logic [4:0]   rk_index;
  logic         rk_last;
`ifdef SPECK_RK_STORE_EN
  logic [4:0]   rk_raddr;
  logic [31:0]  rk_rdata;
`endif

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_k   [ROUNDS];
  logic [31:0] emitted [ROUNDS];

  speck_key_schedule dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key       (key),
    .rk_valid  (rk_valid),
    .rk_ready  (rk_ready),
    .rk_data   (rk_data),
    .rk_index  (rk_index),
    .rk_last   (rk_last)
`ifdef SPECK_RK_STORE_EN
    ,
    .rk_raddr  (rk_raddr),
    .rk_rdata  (rk_rdata)
`endif
  );

  always #5 clk = ~clk;

  // Textbook SPECK recurrence over full l/k arrays rather than a rolling buffer.
  task automatic build_model(input logic [127:0] kk);
    logic [31:0] l [ROUNDS + KW];
    logic [31:0] k [ROUNDS];
    k[0] = kk[31:0];
    l[0] = kk[63:32];
    l[1] = kk[95:64];
    l[2] = kk[127:96];
    for (int i = 0; i < ROUNDS - 1; i++) begin
      l[i+KW-1] = (k[i] + {l[i][7:0], l[i][31:8]}) ^ i;
      k[i+1]    = {k[i][28:0], k[i][31:29]} ^ l[i+KW-1];
    end
    for (int i = 0; i < ROUNDS; i++) exp_k[i] = k[i];
  endtask

  task automatic run_job(input logic [127:0] kk, input bit rand_ready,
                         input int busy_at, input int abort_at);
    int idx = 0;
    int cycles = 0;
    bit busy_done = 1'b0;
    build_model(kk);
    @(negedge clk);
    checks++;
    if (key_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL accept_ready: key_ready=%b want 1", key_ready);
    end
    key = kk;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    while (idx < ROUNDS && cycles < 2000) begin
      cycles++;
      if (idx == abort_at) begin
        rst_n = 1'b0;
        #1;
        checks++;
        if (rk_valid !== 1'b0 || rk_data !== 32'h0 || rk_index !== 5'd0 ||
            key_ready !== 1'b1 || rk_last !== 1'b0) begin
          errors++;
          $display("[TB] FAIL abort_clear: valid=%b data=%h idx=%0d ready=%b last=%b want 0/0/0/1/0",
                   rk_valid, rk_data, rk_index, key_ready, rk_last);
        end
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      checks++;
      if (rk_valid !== 1'b1) begin
        errors++;
        $display("[TB] FAIL rk_valid@%0d: got %b want 1", idx, rk_valid);
      end
      checks++;
      if (rk_index !== 5'(idx)) begin
        errors++;
        $display("[TB] FAIL rk_index: got %0d want %0d", rk_index, idx);
      end
      checks++;
      if (rk_data !== exp_k[idx]) begin
        errors++;
        $display("[TB] FAIL rk_data@%0d: got %h want %h", idx, rk_data, exp_k[idx]);
      end
      checks++;
      if (rk_last !== ((idx == ROUNDS - 1) ? 1'b1 : 1'b0)) begin
        errors++;
        $display("[TB] FAIL rk_last@%0d: got %b want %b", idx, rk_last, idx == ROUNDS - 1);
      end
      rk_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (idx == busy_at && !busy_done) begin
        busy_done = 1'b1;
        checks++;
        if (key_ready !== 1'b0) begin
          errors++;
          $display("[TB] FAIL busy_ready: key_ready=%b want 0", key_ready);
        end
        key = ~kk;
        key_valid = 1'b1;
      end
      if (rk_ready) emitted[idx] = rk_data;
      @(negedge clk);
      key_valid = 1'b0;
      if (rk_ready) idx++;
    end
    checks++;
    if (cycles >= 2000) begin
      errors++;
      $display("[TB] FAIL job_timeout: emitted %0d keys want %0d", idx, ROUNDS);
    end
    checks++;
    if (rk_valid !== 1'b0 || key_ready !== 1'b1 || rk_last !== 1'b0) begin
      errors++;
      $display("[TB] FAIL job_end: valid=%b ready=%b last=%b want 0/1/0", rk_valid, key_ready, rk_last);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    key_valid = 1'b0;
    key = '0;
    rk_ready = 1'b1;
`ifdef SPECK_RK_STORE_EN
    rk_raddr = 5'd0;
`endif
    repeat (3) @(negedge clk);
    checks++;
    if (key_ready !== 1'b1 || rk_valid !== 1'b0 || rk_data !== 32'h0 ||
        rk_index !== 5'd0 || rk_last !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_state: ready=%b valid=%b data=%h idx=%0d last=%b want 1/0/0/0/0",
               key_ready, rk_valid, rk_data, rk_index, rk_last);
    end
`ifdef SPECK_RK_STORE_EN
    rk_raddr = 5'd26;
    #1;
    checks++;
    if (rk_rdata !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_store: got %h want 0", rk_rdata);
    end
`endif
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (rk_valid !== 1'b0 || key_ready !== 1'b1) begin
        errors++;
        $display("[TB] FAIL idle_ready_noeffect: valid=%b ready=%b want 0/1", rk_valid, key_ready);
      end
    end
  endtask

  task automatic test_vector();
    run_job(128'h1b1a1918_13121110_0b0a0908_03020100, 1'b0, -1, -1);
    checks++;
    if (emitted[0] !== 32'h03020100) begin
      errors++;
      $display("[TB] FAIL vector_k0: got %h want 03020100", emitted[0]);
    end
    checks++;
    if (emitted[1] !== 32'h131d0309) begin
      errors++;
      $display("[TB] FAIL vector_k1: got %h want 131d0309", emitted[1]);
    end
  endtask

  task automatic test_store();
`ifdef SPECK_RK_STORE_EN
    for (int a = ROUNDS - 1; a >= 0; a--) begin
      rk_raddr = 5'(a);
      #1;
      checks++;
      if (rk_rdata !== emitted[a]) begin
        errors++;
        $display("[TB] FAIL store_read@%0d: got %h want %h", a, rk_rdata, emitted[a]);
      end
    end
`endif
  endtask

  task automatic test_backpressure();
    for (int n = 0; n < 2; n++)
      run_job({$urandom, $urandom, $urandom, $urandom}, 1'b1, -1, -1);
  endtask

  task automatic test_busy_key();
    run_job({$urandom, $urandom, $urandom, $urandom}, 1'b1, 5, -1);
  endtask

  task automatic test_mid_job_reset();
    run_job({$urandom, $urandom, $urandom, $urandom}, 1'b1, -1, 10);
    run_job({$urandom, $urandom, $urandom, $urandom}, 1'b0, -1, -1);
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 3; n++)
      run_job({$urandom, $urandom, $urandom, $urandom}, n[0], -1, -1);
  endtask

  initial begin
    test_reset();
    test_vector();
    test_store();
    test_backpressure();
    test_busy_key();
    test_mid_job_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
